// File: rtl/silu_scheduler.sv
// silu_scheduler: round-robin arbiter that shares one multi-cycle SiLU core among NUM_REQ requesters.
// Optional build macro SILU_TIMEOUT_EN: abort a WAIT after TIMEOUT cycles and answer with resp_err=1.
module silu_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int START_CYCLES = 1,
  parameter int TIMEOUT      = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_x,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [15:0]           core_x,
  output logic                  core_reset,
  input  logic [15:0]           core_product,
  input  logic                  core_finished,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [15:0]           resp_data,
  output logic                  resp_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) ||
      START_CYCLES < 1 || START_CYCLES > 15 || TIMEOUT < 1) begin : g_bad_params
    $error("silu_scheduler: illegal parameter set");
  end

  state_t              state_r;
  state_t              state_s;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [ID_W-1:0]     rr_ptr_s;
  logic [ID_W:0]       cand_sum_s;
  logic [ID_W-1:0]     cand_s [NUM_REQ];
  logic [ID_W-1:0]     win_s;
  logic                found_s;
  logic [NUM_REQ-1:0]  grant_s;
  logic [3:0]          start_cnt_r;
  logic [3:0]          start_cnt_s;
  logic                start_done_s;
  logic                blank_r;
  logic                capture_s;
  logic                timeout_s;
  logic [15:0]         core_x_r;
  logic [15:0]         core_x_s;
  logic                core_reset_r;
  logic                resp_valid_r;
  logic                busy_r;
  logic [ID_W-1:0]     resp_id_r;
  logic [ID_W-1:0]     resp_id_s;
  logic [15:0]         resp_data_r;
  logic [15:0]         resp_data_s;

  // Candidate search order: rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ.
  always_comb begin
    cand_sum_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum_s = {1'b0, rr_ptr_r} + (ID_W+1)'(i);
      cand_s[i]  = (cand_sum_s >= (ID_W+1)'(NUM_REQ)) ?
                   ID_W'(cand_sum_s - (ID_W+1)'(NUM_REQ)) : ID_W'(cand_sum_s);
    end
  end

  // First requesting candidate wins.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_s   = (!found_s && req_valid[cand_s[i]]) ? cand_s[i] : win_s;
      found_s = found_s | req_valid[cand_s[i]];
    end
  end

  // Grant is combinational so the operand transfers on the same edge that leaves IDLE.
  always_comb begin
    grant_s = '0;
    if (state_r == ST_IDLE && found_s && !reset) begin
      grant_s[win_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign start_done_s = (start_cnt_r == 4'(START_CYCLES - 1));
  // blank_r marks the first WAIT cycle, where a leftover Finished from the last run may still be high.
  assign capture_s    = (state_r == ST_WAIT) && !blank_r && core_finished;

`ifdef SILU_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt_r;
  logic              resp_err_r;

  assign timeout_s = (state_r == ST_WAIT) && !capture_s && (wait_cnt_r == WAIT_W'(TIMEOUT - 1));

  // WAIT cycle counter, zero on every entry into WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (state_r == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Error flag tracks which event ended WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_err_r <= 1'b0;
    end else if (capture_s) begin
      resp_err_r <= 1'b0;
    end else if (timeout_s) begin
      resp_err_r <= 1'b1;
    end else begin
      resp_err_r <= resp_err_r;
    end
  end

  assign resp_err = resp_err_r;
`else
  assign timeout_s = 1'b0;
  assign resp_err  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (start_done_s) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_START;
        end
      end
      ST_WAIT: begin
        if (capture_s || timeout_s) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values; operand and id only move on a grant.
  always_comb begin
    core_x_s    = core_x_r;
    resp_id_s   = resp_id_r;
    resp_data_s = resp_data_r;
    rr_ptr_s    = rr_ptr_r;
    start_cnt_s = start_cnt_r;
    case (state_r)
      ST_IDLE: begin
        start_cnt_s = 4'd0;
        if (found_s) begin
          core_x_s  = req_x[{win_s, 4'b0000} +: 16];
          resp_id_s = win_s;
          rr_ptr_s  = (win_s == ID_W'(NUM_REQ - 1)) ? '0 : win_s + ID_W'(1);
        end else begin
          rr_ptr_s  = rr_ptr_r;
        end
      end
      ST_START: start_cnt_s = start_cnt_r + 4'd1;
      ST_WAIT: begin
        if (capture_s) begin
          resp_data_s = core_product;
        end else if (timeout_s) begin
          resp_data_s = 16'h0000;
        end else begin
          resp_data_s = resp_data_r;
        end
      end
      ST_RESP: resp_data_s = resp_data_r;
      default: core_x_s = core_x_r;
    endcase
  end

  // Registered outputs and datapath; the core is held in reset in IDLE and START.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_r     <= '0;
      start_cnt_r  <= 4'd0;
      blank_r      <= 1'b0;
      core_x_r     <= 16'h0000;
      core_reset_r <= 1'b1;
      resp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      resp_id_r    <= '0;
      resp_data_r  <= 16'h0000;
    end else begin
      rr_ptr_r     <= rr_ptr_s;
      start_cnt_r  <= start_cnt_s;
      blank_r      <= (state_r == ST_START);
      core_x_r     <= core_x_s;
      core_reset_r <= (state_s == ST_IDLE) || (state_s == ST_START);
      resp_valid_r <= (state_s == ST_RESP);
      busy_r       <= (state_s != ST_IDLE);
      resp_id_r    <= resp_id_s;
      resp_data_r  <= resp_data_s;
    end
  end

  assign req_ready  = grant_s;
  assign core_x     = core_x_r;
  assign core_reset = core_reset_r;
  assign resp_valid = resp_valid_r;
  assign busy       = busy_r;
  assign resp_id    = resp_id_r;
  assign resp_data  = resp_data_r;

endmodule

// File: tb/tb_silu_scheduler.sv
// tb_silu_scheduler: table vectors, hand sequences and random traffic against a round-robin model,
// with a behavioural SiLU core stub (programmable latency, stale Finished, never-finish).
module tb_silu_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_x;
  logic [3:0]  req_ready;
  logic [15:0] core_x;
  logic        core_reset;
  logic [15:0] core_product;
  logic        core_finished;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int rr_m  = 0;
  int lat   = 10;
  bit stale = 1'b0;
  bit never = 1'b0;
  int ccnt  = 0;
  logic stale_phase;

  silu_scheduler #(.NUM_REQ(4), .ID_W(2), .START_CYCLES(1), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .core_x(core_x), .core_reset(core_reset), .core_product(core_product),
    .core_finished(core_finished), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] stub(input logic [15:0] x);
    if (x == 16'hBC00) return 16'hB44D;
    return {x[14:0], x[15]};
  endfunction

  // Core stub: counts cycles since core_reset fell, Finished once the count reaches lat.
  always @(posedge clk) begin
    if (core_reset) ccnt <= 0;
    else if (ccnt < 1000) ccnt <= ccnt + 1;
  end
  assign stale_phase   = stale && (core_reset || ccnt == 0);
  assign core_finished = !never && (stale_phase || (!core_reset && ccnt >= lat));
  assign core_product  = stale_phase ? 16'hDEAD : stub(core_x);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) if (mask[(rr_m + i) % 4]) return (rr_m + i) % 4;
    return -1;
  endfunction

  task automatic reset_pulse(input logic [3:0] mask);
    req_valid = mask; resp_ready = 1'b0;
    reset = 1'b1; #1;
    chk("reset_vals", {req_ready, core_x, core_reset, resp_valid, resp_id, resp_data, resp_err, busy},
        {4'h0, 16'h0000, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0});
    @(negedge clk); #1;
    reset = 1'b0; rr_m = 0; #1;
  endtask

  // One full transaction: grant, START, WAIT, RESP with bp cycles of backpressure, acceptance.
  task automatic do_op(input logic [3:0] mask, input logic [63:0] xs, input int bp,
                       input int exp_id, input string tag);
    int cyc; bit stable; logic [15:0] xe; logic [39:0] snap;
    xe = xs[16*exp_id +: 16];
    req_valid = mask; req_x = xs; resp_ready = (bp == 0); #1;
    cyc = 0;
    while (req_ready == 4'b0000 && cyc < 40) begin @(negedge clk); #1; cyc++; end
    chk({tag, " grant"}, req_ready, 64'(4'b0001 << exp_id));
    @(negedge clk); #1;
    chk({tag, " start"}, {req_ready, busy, core_reset, core_x}, {4'b0000, 1'b1, 1'b1, xe});
    @(negedge clk); #1;
    chk({tag, " wait_entry"}, {core_reset, busy}, {1'b0, 1'b1});
    stable = 1'b1; cyc = 0;
    while (!resp_valid && cyc < 300) begin
      if (core_x !== xe || req_ready !== 4'b0000) stable = 1'b0;
      @(negedge clk); #1; cyc++;
    end
    chk({tag, " in_flight_stable"}, stable, 1'b1);
    chk({tag, " resp"}, {resp_valid, resp_id, resp_data, resp_err, core_x},
        {1'b1, 2'(exp_id), stub(xe), 1'b0, xe});
    snap = {resp_valid, resp_id, resp_data, req_ready, core_x, 1'b0};
    stable = 1'b1;
    for (int k = 0; k < bp; k++) begin
      @(negedge clk); #1;
      if ({resp_valid, resp_id, resp_data, req_ready, core_x, 1'b0} !== snap) stable = 1'b0;
    end
    if (bp > 0) chk({tag, " backpressure_hold"}, stable, 1'b1);
    resp_ready = 1'b1;
    @(negedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, " after_accept"}, {resp_valid, busy, core_reset}, {1'b0, 1'b0, 1'b1});
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [63:0] xs;
    int          bp;
    int          exp_id;
  } vec_t;

  vec_t tbl[8];
  int   order[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc; int n; int e; logic [3:0] m; logic [63:0] xs;
    tbl[0] = '{4'b0001, 64'h3333_2222_1111_0000, 0, 0};
    tbl[1] = '{4'b0100, 64'h4444_BC00_1212_7777, 0, 2};
    tbl[2] = '{4'b1111, 64'h8001_0F0F_A5A5_1357, 0, 3};
    tbl[3] = '{4'b1111, 64'h0102_0304_0506_0708, 0, 0};
    tbl[4] = '{4'b0101, 64'hFFFF_7FFF_8000_0001, 5, 2};
    tbl[5] = '{4'b0011, 64'h1111_2222_3333_4444, 0, 0};
    tbl[6] = '{4'b1000, 64'hCAFE_0000_0000_0000, 2, 3};
    tbl[7] = '{4'b0110, 64'h0000_BEEF_F00D_0000, 0, 1};
    order  = '{0, 1, 2, 3, 0, 1};

    reset = 1'b0; req_valid = 4'b0000; req_x = 64'h0; resp_ready = 1'b0;
    #2;
    reset_pulse(4'b1111);

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].mask, tbl[i].xs, tbl[i].bp, tbl[i].exp_id, $sformatf("vec%0d", i));
      rr_m = (tbl[i].exp_id + 1) % 4;
    end

    // All four requesting continuously from a fresh reset.
    reset_pulse(4'b1111);
    for (int i = 0; i < 6; i++) begin
      do_op(4'b1111, 64'h4000_3000_2000_1000 + 64'(i), 0, order[i], $sformatf("rr%0d", i));
      rr_m = (order[i] + 1) % 4;
    end

    // Stale Finished held high through START and the blanking cycle.
    stale = 1'b1; lat = 4;
    e = model_pick(4'b0001);
    do_op(4'b0001, 64'h0000_0000_0000_0BAD, 0, e, "stale");
    rr_m = (e + 1) % 4;
    stale = 1'b0; lat = 10;

    // Reset in the middle of WAIT, then grant from pointer 0.
    req_x = 64'h1111_2222_3333_4444; req_valid = 4'b0010; resp_ready = 1'b0; #1;
    cyc = 0;
    while (req_ready == 4'b0000 && cyc < 40) begin @(negedge clk); #1; cyc++; end
    chk("midwait grant", req_ready, 4'b0010);
    for (int k = 0; k < 3; k++) begin @(negedge clk); #1; end
    chk("midwait in_wait", {busy, core_reset, resp_valid}, {1'b1, 1'b0, 1'b0});
    reset_pulse(4'b0110);
    do_op(4'b0110, 64'h1111_2222_3333_4444, 0, 1, "post_reset");
    rr_m = 2;

`ifdef SILU_TIMEOUT_EN
    never = 1'b1;
    e = model_pick(4'b0001);
    req_x = 64'h0000_0000_0000_1234; req_valid = 4'b0001; resp_ready = 1'b0; #1;
    cyc = 0;
    while (req_ready == 4'b0000 && cyc < 40) begin @(negedge clk); #1; cyc++; end
    chk("timeout grant", req_ready, 4'b0001);
    @(negedge clk); #1;
    n = 0; cyc = 0;
    while (!resp_valid && cyc < 100) begin
      @(negedge clk); #1; cyc++;
      if (busy && !resp_valid && !core_reset) n++;
    end
    chk("timeout wait_cycles", 64'(n), 64'd20);
    chk("timeout resp", {resp_valid, resp_id, resp_data, resp_err}, {1'b1, 2'(e), 16'h0000, 1'b1});
    resp_ready = 1'b1; @(negedge clk); #1; resp_ready = 1'b0;
    chk("timeout accept", {resp_valid, busy, core_reset}, {1'b0, 1'b0, 1'b1});
    rr_m = (e + 1) % 4;
    never = 1'b0;
`endif

    // Random traffic against the round-robin model.
    for (int i = 0; i < 40; i++) begin
      m     = 4'($urandom_range(1, 15));
      xs    = {$urandom, $urandom};
      lat   = $urandom_range(1, 12);
      stale = 1'($urandom_range(0, 1));
      e     = model_pick(m);
      do_op(m, xs, $urandom_range(0, 3), e, $sformatf("rand%0d", i));
      rr_m  = (e + 1) % 4;
    end
    stale = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/silu_scheduler.md
Name: silu_scheduler

Overview:
- Round-robin arbiter and sequencer that shares one multi-cycle SiLU core (16-bit x in, 16-bit product out, reset-to-start, Finished when done) among NUM_REQ activation requesters.
- Latches the winning operand, starts the core with a reset pulse, waits for Finished, and returns the result tagged with the requester id over a valid/ready response channel.
- Sits between the conv post-processing lanes and the single activation core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, response id width; must equal clog2(NUM_REQ).
- START_CYCLES, 1, cycles core_reset is held high per operation (1..15).
- TIMEOUT, 1023, max cycles in WAIT before abort (used only with SILU_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_x  in  16*NUM_REQ  operands; requester i uses bits [16*i+15:16*i].
- req_ready  out  NUM_REQ  one-hot grant; operand accepted when valid&ready.
- core_x  out  16  operand to SiLU core.
- core_reset  out  1  start/reset pulse to SiLU core.
- core_product  in  16  SiLU core result.
- core_finished  in  1  SiLU core done (level).
- resp_valid  out  1  result valid.
- resp_ready  in  1  downstream accepts result.
- resp_id  out  ID_W  requester index of result.
- resp_data  out  16  result.
- resp_err  out  1  result aborted by timeout.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: req_ready=0, core_x=0, core_reset=1 (core held in reset while idle), resp_valid=0, resp_id=0, resp_data=0, resp_err=0, busy=0, rr pointer=0, all counters=0.
- States:
  - IDLE: if any req_valid, pick the first set bit searching upward from rr_ptr with wrap; assert req_ready for that bit for one cycle (combinational from state and valid, registered transfer); latch core_x=req_x[winner] and id; set rr_ptr=winner+1 mod NUM_REQ; go to START.
  - START: core_reset=1 for START_CYCLES cycles with core_x stable, then core_reset=0 and go to WAIT.
  - WAIT: the first cycle after START is blanking; core_finished is ignored there to reject a stale Finished. From the second WAIT cycle, core_finished=1 latches resp_data=core_product and resp_err=0, then go to RESP.
  - RESP: resp_valid=1; hold resp_data, resp_id and resp_err stable until resp_ready; on acceptance clear resp_valid, set core_reset=1 and return to IDLE.
- core_x changes only in IDLE on a grant. It is stable from START through RESP.
- Only one operation is in flight. All req_ready are 0 outside IDLE.
- Minimum issue-to-issue spacing: START_CYCLES + 1 blanking cycle + core latency + 1 RESP cycle + 1 IDLE cycle.
- Requester dropping valid before grant: no effect; it is not remembered.
- Simultaneous requests: exactly one grant per IDLE cycle. Each continuously requesting requester is served within NUM_REQ grants.
- resp_ready held high: RESP lasts exactly 1 cycle.
- Async reset mid-operation (any state): all outputs return to reset values immediately; in-flight result is discarded; core_reset=1 restarts the core.

Optional Feature:
- SILU_TIMEOUT_EN defined:
  - A wait counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no core_finished, go to RESP with resp_data=16'h0000 and resp_err=1. Exiting RESP re-resets the core.
- Undefined: no counter logic; WAIT waits indefinitely; resp_err is tied to 0.

Test Plan:
- Reset then single request: req_valid=4'b0001, req_x[0]=16'h0000, core stub finishes after 10 cycles with product 16'h0000 -> req_ready pulses 4'b0001 once; core_reset high exactly 1 cycle; resp_valid with resp_id=0, resp_data=16'h0000, resp_err=0.
- Requester 2 with x=16'hBC00 (-1.0) on real Silu core -> resp_id=2; resp_data equals core_product sampled at Finished (about 16'hB44D, -0.269); core_x stays 16'hBC00 until RESP acceptance.
- All four requesting continuously, resp_ready=1 -> grant order 0,1,2,3,0,1; no requester granted twice within 4 grants.
- Stale Finished: stub keeps core_finished=1 through START and the blanking cycle -> no early capture; result taken only in the second WAIT cycle or later.
- Backpressure: resp_ready=0 for 5 cycles while in RESP -> resp_valid, resp_id and resp_data held constant; no new grant until acceptance; IDLE and next grant follow acceptance.
- Reset asserted mid-WAIT -> outputs at reset values in the same cycle; after release, a pending request is granted from rr_ptr=0. With SILU_TIMEOUT_EN and TIMEOUT=20 and a core that never finishes -> resp_err=1 and resp_data=0 after 20 WAIT cycles.
